trigger_engine: RTL and testbench

Parametrised threshold trigger and acquisition sequencer. It sits between the deserialised ADC sample words and the capture FIFO, and is controlled by the command processor. It extends the single-lane rising threshold trigger to all lanes of a sample word, and adds falling-edge, external and auto (timeout) trigger modes, trigger-lane reporting and a FIFO-overflow flag.

---
 rtl/trigger_engine_if.sv | 13 +
 rtl/trigger_engine.sv | 204 ++++++++++++++++++++
 tb/tb_trigger_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_engine_if.sv
// Capture-FIFO side of the trigger engine: write strobe and data towards the FIFO,
// full flag back from it.
interface trigger_engine_if #(
    parameter int NSAMP = 40,
    parameter int SW    = 12
);
    logic                fifo_wr;
    logic [NSAMP*SW-1:0] fifo_data;
    logic                fifo_full;

    modport master (output fifo_wr, output fifo_data, input fifo_full);
    modport slave  (input fifo_wr, input fifo_data, output fifo_full);
endinterface

// File: rtl/trigger_engine.sv
// Threshold trigger and acquisition sequencer: rising/falling/external/auto triggers
// evaluated over every lane of a sample word, with the capture streamed into a FIFO.
module trigger_engine #(
    parameter int NSAMP = 40,
    parameter int SW    = 12,
    parameter int CNTW  = 16,
    parameter int LW    = 6
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NSAMP*SW-1:0]  samples_i,
    input  logic                 arm_i,
    input  logic [1:0]           trig_type_i,
    input  logic signed [SW-1:0] lower_i,
    input  logic signed [SW-1:0] upper_i,
    input  logic [CNTW-1:0]      length_i,
    input  logic [CNTW-1:0]      timeout_i,
    input  logic                 ext_trig_i,
    input  logic                 readout_done_i,
    trigger_engine_if.master     fifo,
    output logic                 busy_o,
    output logic                 ready_o,
    output logic [LW-1:0]        trig_lane_o,
    output logic                 auto_o,
    output logic                 overflow_o,
    output logic [CNTW-1:0]      capture_count_o,
    output logic [CNTW-1:0]      event_count_o
);
    typedef enum logic [1:0] {TT_IMM, TT_RISE, TT_FALL, TT_EXT} trigType_e;
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_CAPTURE, S_DONE} state_e;

    state_e                state_q;
    trigType_e             trigType_q;
    logic signed [SW-1:0]  lower_q;
    logic signed [SW-1:0]  upper_q;
    logic [CNTW-1:0]       length_q;
    logic [CNTW-1:0]       timeout_q;
    logic [CNTW-1:0]       toCnt_q;
    logic [CNTW-1:0]       capCnt_q;
    logic [CNTW-1:0]       evCnt_q;
    logic                  armed_q;
    logic                  armed_d;
    logic                  busy_q;
    logic                  ready_q;
    logic                  auto_q;
    logic                  overflow_q;
    logic                  wr_q;
    logic                  extNow_q;
    logic                  extPrev_q;
    logic [LW-1:0]         trigLane_q;
    logic [NSAMP*SW-1:0]   s1_q;
    logic [NSAMP*SW-1:0]   data_q;

    logic [NSAMP-1:0]      below;
    logic [NSAMP-1:0]      above;
    logic [NSAMP-1:0]      armLanes;
    logic [NSAMP-1:0]      fireLanes;
    logic                  pre;
    logic                  edgeHit;
    logic [LW-1:0]         edgeLane;
    logic                  realFire;
    logic [LW-1:0]         fireLane;
    logic                  toHit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_q      <= '0;
            data_q    <= '0;
            extNow_q  <= 1'b0;
            extPrev_q <= 1'b0;
        end else begin
            s1_q      <= samples_i;
            data_q    <= s1_q;
            extNow_q  <= ext_trig_i;
            extPrev_q <= extNow_q;
        end
    end

    always_comb begin
        for (int k = 0; k < NSAMP; k++) begin
            below[k] = $signed(s1_q[k*SW +: SW]) < lower_q;
            above[k] = $signed(s1_q[k*SW +: SW]) > upper_q;
        end
    end

    // Falling mode is the mirror of rising: swap which condition arms and which fires.
    // A lane may only fire if the flag was already armed or an earlier lane armed it.
    always_comb begin
        armLanes  = (trigType_q == TT_FALL) ? above : below;
        fireLanes = (trigType_q == TT_FALL) ? below : above;
        pre       = armed_q;
        edgeHit   = 1'b0;
        edgeLane  = '0;
        for (int k = 0; k < NSAMP; k++) begin
            if (!edgeHit && pre && fireLanes[k]) begin
                edgeHit  = 1'b1;
                edgeLane = LW'(k);
            end
            pre = pre | armLanes[k];
        end
        armed_d = pre;
    end

    always_comb begin
        realFire = 1'b0;
        fireLane = '0;
        if (trigType_q == TT_EXT) begin
            realFire = extNow_q & ~extPrev_q;
        end else if (trigType_q == TT_RISE || trigType_q == TT_FALL) begin
            realFire = edgeHit;
            fireLane = edgeLane;
        end
        toHit = (timeout_q != '0) && ((toCnt_q + CNTW'(1)) == timeout_q);
    end

    // The word that fires is written in the same edge, so it is the first captured word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            trigType_q <= TT_IMM;
            lower_q    <= '0;
            upper_q    <= '0;
            length_q   <= '0;
            timeout_q  <= '0;
            toCnt_q    <= '0;
            capCnt_q   <= '0;
            evCnt_q    <= '0;
            armed_q    <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            auto_q     <= 1'b0;
            overflow_q <= 1'b0;
            wr_q       <= 1'b0;
            trigLane_q <= '0;
        end else begin
            wr_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (arm_i) begin
                        trigType_q <= trigType_e'(trig_type_i);
                        lower_q    <= lower_i;
                        upper_q    <= upper_i;
                        length_q   <= length_i;
                        timeout_q  <= timeout_i;
                        armed_q    <= 1'b0;
                        toCnt_q    <= '0;
                        auto_q     <= 1'b0;
                        overflow_q <= 1'b0;
                        capCnt_q   <= '0;
                        busy_q     <= 1'b1;
                        if (trigType_e'(trig_type_i) == TT_IMM) begin
                            trigLane_q <= '0;
                            state_q    <= S_CAPTURE;
                        end else begin
                            state_q    <= S_ARM;
                        end
                    end
                end
                S_ARM: begin
                    armed_q <= armed_d;
                    if (timeout_q != '0) toCnt_q <= toCnt_q + CNTW'(1);
                    if (realFire || toHit) begin
                        trigLane_q <= realFire ? fireLane : '0;
                        auto_q     <= ~realFire;
                        state_q    <= S_CAPTURE;
                        if (length_q != '0 && !fifo.fifo_full) begin
                            wr_q     <= 1'b1;
                            capCnt_q <= CNTW'(1);
                        end
                    end
                end
                S_CAPTURE: begin
                    if (capCnt_q == length_q || fifo.fifo_full) begin
                        overflow_q <= (capCnt_q != length_q);
                        state_q    <= S_DONE;
                        busy_q     <= 1'b0;
                        ready_q    <= 1'b1;
                        evCnt_q    <= evCnt_q + CNTW'(1);
                    end else begin
                        wr_q     <= 1'b1;
                        capCnt_q <= capCnt_q + CNTW'(1);
                    end
                end
                S_DONE: begin
                    if (readout_done_i) begin
                        ready_q <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign fifo.fifo_wr    = wr_q;
    assign fifo.fifo_data  = data_q;
    assign busy_o          = busy_q;
    assign ready_o         = ready_q;
    assign trig_lane_o     = trigLane_q;
    assign auto_o          = auto_q;
    assign overflow_o      = overflow_q;
    assign capture_count_o = capCnt_q;
    assign event_count_o   = evCnt_q;
endmodule

// File: tb/tb_trigger_engine.sv
// Bench for trigger_engine: table of trigger scenarios plus hand sequences for
// immediate, overflow, auto-trigger, external and reset cases; FIFO writes scoreboarded.
module tb_trigger_engine;
    localparam int NSAMP = 40;
    localparam int SW    = 12;
    localparam int CNTW  = 16;
    localparam int LW    = 6;
    localparam int W     = NSAMP * SW;

    typedef struct {
        int trigType;
        int l0a; int v0a; int l0b; int v0b;
        int l1;  int v1;
        int l2;  int v2;
        int fireIdx;
        int expLane;
        int length;
    } vec_t;

    logic                 clk = 1'b0;
    logic                 rstn = 1'b1;
    logic [W-1:0]         samples_i = '0;
    logic                 arm_i = 1'b0;
    logic [1:0]           trig_type_i = '0;
    logic signed [SW-1:0] lower_i = -12'sd10;
    logic signed [SW-1:0] upper_i = 12'sd10;
    logic [CNTW-1:0]      length_i = '0;
    logic [CNTW-1:0]      timeout_i = '0;
    logic                 ext_trig_i = 1'b0;
    logic                 readout_done_i = 1'b0;
    logic                 busy_o, ready_o, auto_o, overflow_o;
    logic [LW-1:0]        trig_lane_o;
    logic [CNTW-1:0]      capture_count_o, event_count_o;

    trigger_engine_if #(.NSAMP(NSAMP), .SW(SW)) fifoIf();

    trigger_engine #(.NSAMP(NSAMP), .SW(SW), .CNTW(CNTW), .LW(LW)) dut (
        .clk(clk), .rstn(rstn), .samples_i(samples_i), .arm_i(arm_i),
        .trig_type_i(trig_type_i), .lower_i(lower_i), .upper_i(upper_i),
        .length_i(length_i), .timeout_i(timeout_i), .ext_trig_i(ext_trig_i),
        .readout_done_i(readout_done_i), .fifo(fifoIf), .busy_o(busy_o),
        .ready_o(ready_o), .trig_lane_o(trig_lane_o), .auto_o(auto_o),
        .overflow_o(overflow_o), .capture_count_o(capture_count_o),
        .event_count_o(event_count_o)
    );

    always #5 clk = ~clk;

    int           nVec = 0;
    int           nFail = 0;
    int           tick = 0;
    int           wIdx = 0;
    int           pushLo = 1000;
    int           pushHi = 1000;
    int           evExp = 0;
    logic         armNext = 1'b0;
    logic         rdNext = 1'b0;
    logic         extLvl = 1'b0;
    logic         fullLvl = 1'b0;
    logic [W-1:0] expQ [$];
    vec_t         vecs [9];

    // Every write the DUT issues must match the oldest word the model expected to be captured.
    always @(negedge clk) begin
        if (rstn && fifoIf.fifo_wr) begin
            nVec++;
            if (expQ.size() == 0) begin
                nFail++;
                $display("[TB] FAIL unexpected_write: got data %0h, required no write", fifoIf.fifo_data);
            end else begin
                logic [W-1:0] expWord;
                expWord = expQ.pop_front();
                if (fifoIf.fifo_data !== expWord) begin
                    nFail++;
                    $display("[TB] FAIL fifo_data: got %0h required %0h", fifoIf.fifo_data, expWord);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [W-1:0] makeWord(input int t, input int la, input int va,
                                              input int lb, input int vb);
        logic [W-1:0] w;
        for (int k = 0; k < NSAMP; k++) w[k*SW +: SW] = SW'(((t + k) % 5) - 2);
        if (la >= 0) w[la*SW +: SW] = SW'(va);
        if (lb >= 0) w[lb*SW +: SW] = SW'(vb);
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic stepCycle(input logic [W-1:0] w);
        @(posedge clk);
        #1;
        tick++;
        samples_i      = w;
        arm_i          = armNext;
        armNext        = 1'b0;
        readout_done_i = rdNext;
        rdNext         = 1'b0;
        ext_trig_i     = extLvl;
        fifoIf.fifo_full = fullLvl;
        if (wIdx >= pushLo && wIdx < pushHi) expQ.push_back(w);
        wIdx++;
        @(negedge clk);
    endtask

    task automatic stepBg();
        stepCycle(makeWord(tick + 1, -1, 0, -1, 0));
    endtask

    task automatic configure(input int tt, input int len, input int tmo);
        trig_type_i = 2'(tt);
        lower_i     = -12'sd10;
        upper_i     = 12'sd10;
        length_i    = CNTW'(len);
        timeout_i   = CNTW'(tmo);
    endtask

    task automatic waitReady(input string name, input int limit);
        for (int i = 0; i < limit && !ready_o; i++) stepBg();
        checkOutput({name, "_ready"}, ready_o, 1);
    endtask

    task automatic finishEvent(input string name, input int expCnt);
        checkOutput({name, "_evcnt"}, event_count_o, evExp);
        rdNext = 1'b1;
        stepBg();
        stepBg();
        checkOutput({name, "_ready_clr"}, ready_o, 0);
        checkOutput({name, "_busy_clr"}, busy_o, 0);
        checkOutput({name, "_cnt_hold"}, capture_count_o, expCnt);
        checkOutput({name, "_queue_empty"}, expQ.size(), 0);
        pushLo = 1000;
        pushHi = 1000;
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        string name;
        name = $sformatf("row%0d", idx);
        configure(v.trigType, v.length, 0);
        pushLo  = v.fireIdx;
        pushHi  = v.fireIdx + v.length;
        wIdx    = -1;
        armNext = 1'b1;
        stepBg();
        stepCycle(makeWord(tick + 1, v.l0a, v.v0a, v.l0b, v.v0b));
        stepCycle(makeWord(tick + 1, v.l1, v.v1, -1, 0));
        stepCycle(makeWord(tick + 1, v.l2, v.v2, -1, 0));
        waitReady(name, 40);
        evExp++;
        checkOutput({name, "_lane"}, trig_lane_o, v.expLane);
        checkOutput({name, "_auto"}, auto_o, 0);
        checkOutput({name, "_ovf"}, overflow_o, 0);
        checkOutput({name, "_count"}, capture_count_o, v.length);
        finishEvent(name, v.length);
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_wr"}, fifoIf.fifo_wr, 0);
        checkOutput({name, "_data"}, |fifoIf.fifo_data, 0);
        checkOutput({name, "_busy"}, busy_o, 0);
        checkOutput({name, "_ready"}, ready_o, 0);
        checkOutput({name, "_lane"}, trig_lane_o, 0);
        checkOutput({name, "_auto"}, auto_o, 0);
        checkOutput({name, "_ovf"}, overflow_o, 0);
        checkOutput({name, "_count"}, capture_count_o, 0);
        checkOutput({name, "_evcnt"}, event_count_o, 0);
    endtask

    initial begin
        bit anyWr;
        bit anyIdle;

        // trigType, word0 (two overrides), word1, word2, fire word index, lane, length
        vecs[0] = '{1, 3, -20, -1, 0,  7,  20, -1,   0, 1, 7, 3};
        vecs[1] = '{1, 3, -20,  7, 20, -1,  0, -1,   0, 0, 7, 2};
        vecs[2] = '{1, 3,  20,  7, -20, -1, 0,  0,  20, 2, 0, 1};
        vecs[3] = '{2, 3,  20, -1, 0,  7, -20, -1,   0, 1, 7, 4};
        vecs[4] = '{2, 3,  20,  7, -20, -1, 0, -1,   0, 0, 7, 1};
        vecs[5] = '{2, 3, -20,  7, 20,  7,  20,  0, -20, 2, 0, 2};
        vecs[6] = '{1, 0, -20, NSAMP-1, 20, -1, 0, -1, 0, 0, NSAMP-1, 2};
        vecs[7] = '{1, 2, -11,  5, 10,  6,  11, -1,   0, 1, 6, 3};
        vecs[8] = '{2, 2,  11,  5, -10, 6, -11, -1,   0, 1, 6, 1};

        fifoIf.fifo_full = 1'b0;
        #2 rstn = 1'b0;
        @(negedge clk);
        checkAllZero("reset");
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] immediate mode, length 5");
        configure(0, 5, 0);
        pushLo = -1; pushHi = 4; wIdx = -1;
        armNext = 1'b1;
        stepBg();
        checkOutput("imm_c0_wr", fifoIf.fifo_wr, 0);
        for (int c = 1; c <= 8; c++) begin
            stepBg();
            checkOutput($sformatf("imm_c%0d_wr", c), fifoIf.fifo_wr, (c >= 2 && c <= 6) ? 1 : 0);
            if (c == 1) checkOutput("imm_busy", busy_o, 1);
        end
        evExp++;
        checkOutput("imm_ready", ready_o, 1);
        checkOutput("imm_count", capture_count_o, 5);
        finishEvent("imm", 5);

        $display("[TB] immediate mode, length 0");
        configure(0, 0, 0);
        wIdx = -1;
        armNext = 1'b1;
        stepBg();
        stepBg();
        checkOutput("len0_c1_ready", ready_o, 0);
        stepBg();
        checkOutput("len0_c2_ready", ready_o, 1);
        checkOutput("len0_count", capture_count_o, 0);
        evExp++;
        finishEvent("len0", 0);

        $display("[TB] FIFO full after three writes");
        configure(0, 10, 0);
        pushLo = -1; pushHi = 2; wIdx = -1;
        armNext = 1'b1;
        stepBg();
        for (int c = 1; c <= 3; c++) stepBg();
        fullLvl = 1'b1;
        stepBg();
        waitReady("ovf", 10);
        evExp++;
        checkOutput("ovf_flag", overflow_o, 1);
        checkOutput("ovf_count", capture_count_o, 3);
        configure(0, 5, 0);
        armNext = 1'b1;
        stepBg();
        stepBg();
        checkOutput("done_arm_ready", ready_o, 1);
        checkOutput("done_arm_busy", busy_o, 0);
        checkOutput("done_arm_count", capture_count_o, 3);
        fullLvl = 1'b0;
        finishEvent("ovf", 3);

        for (int i = 0; i < 9; i++) applyStimulus(i, vecs[i]);

        $display("[TB] auto trigger, timeout 100");
        configure(1, 2, 100);
        pushLo = 98; pushHi = 100; wIdx = -1;
        armNext = 1'b1;
        stepBg();
        anyWr = 1'b0;
        for (int c = 1; c <= 101; c++) begin
            stepBg();
            if (c <= 100) anyWr |= fifoIf.fifo_wr;
            if (c == 101) begin
                checkOutput("auto_wr_at_101", fifoIf.fifo_wr, 1);
                checkOutput("auto_flag", auto_o, 1);
                checkOutput("auto_lane", trig_lane_o, 0);
            end
        end
        checkOutput("auto_no_early_wr", anyWr, 0);
        waitReady("auto", 10);
        evExp++;
        finishEvent("auto", 2);

        $display("[TB] timeout 0 never fires");
        configure(1, 1, 0);
        pushLo = 301; pushHi = 302; wIdx = -1;
        armNext = 1'b1;
        stepBg();
        anyWr = 1'b0;
        anyIdle = 1'b0;
        for (int c = 0; c < 300; c++) begin
            stepBg();
            anyWr |= fifoIf.fifo_wr;
            anyIdle |= ~busy_o;
        end
        checkOutput("tmo0_no_wr", anyWr, 0);
        checkOutput("tmo0_stays_busy", anyIdle, 0);
        checkOutput("tmo0_auto_clr", auto_o, 0);
        stepCycle(makeWord(tick + 1, 0, -20, -1, 0));
        stepCycle(makeWord(tick + 1, 5, 20, -1, 0));
        waitReady("tmo0", 10);
        evExp++;
        checkOutput("tmo0_lane", trig_lane_o, 5);
        checkOutput("tmo0_auto", auto_o, 0);
        finishEvent("tmo0", 1);

        $display("[TB] external trigger");
        configure(3, 2, 0);
        extLvl = 1'b1;
        stepBg();
        pushLo = 7; pushHi = 9; wIdx = -1;
        armNext = 1'b1;
        stepBg();
        anyWr = 1'b0;
        for (int c = 0; c < 5; c++) begin
            stepBg();
            anyWr |= fifoIf.fifo_wr;
        end
        extLvl = 1'b0;
        stepBg();
        stepBg();
        anyWr |= fifoIf.fifo_wr;
        checkOutput("ext_level_no_fire", anyWr, 0);
        extLvl = 1'b1;
        stepBg();
        waitReady("ext", 10);
        evExp++;
        checkOutput("ext_lane", trig_lane_o, 0);
        checkOutput("ext_auto", auto_o, 0);
        checkOutput("ext_count", capture_count_o, 2);
        finishEvent("ext", 2);

        $display("[TB] reset in the middle of a capture");
        configure(0, 10, 0);
        pushLo = -1; pushHi = 9; wIdx = -1;
        armNext = 1'b1;
        stepBg();
        for (int c = 1; c <= 4; c++) stepBg();
        checkOutput("mid_wr_before_reset", fifoIf.fifo_wr, 1);
        #2 rstn = 1'b0;
        #1;
        checkAllZero("midrst");
        expQ.delete();
        pushLo = 1000; pushHi = 1000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        anyWr = 1'b0;
        for (int c = 0; c < 20; c++) begin
            stepBg();
            anyWr |= fifoIf.fifo_wr;
        end
        checkOutput("postrst_no_wr", anyWr, 0);
        checkOutput("postrst_busy", busy_o, 0);
        checkOutput("postrst_evcnt", event_count_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end
endmodule
